// File: rtl/pipelined_add_sub.sv
// WIDTH-bit two's-complement adder/subtractor with the carry chain cut
// into STAGES registered slices under a valid/ready, global-stall handshake.
//
// Ports:
//   CLK, RST            clock (rising edge), async active-high reset
//   IN_VALID, IN_READY  operand handshake (A, B, SnA: 0 = A+B, 1 = A-B)
//   OUT_VALID, OUT_READY result handshake
//   Y, CO, OVF, ZERO    result, raw MSB carry, signed overflow, Y == 0
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SnA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OVF,
  output logic             ZERO
);

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH
      || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_add_sub: bad WIDTH/STAGES");
  end

  localparam int S = WIDTH / STAGES;

  logic                          adv;
  logic                          take;

  logic [STAGES-1:0]             v_r;
  logic [STAGES-1:0]             c_r;
  logic [STAGES-1:0][WIDTH-1:0]  a_r;
  logic [STAGES-1:0][WIDTH-1:0]  bx_r;
  logic [STAGES-1:0][WIDTH-1:0]  y_r;
  logic                          ovf_r;
  logic                          zero_r;

  logic [STAGES-1:0]             c_n;
  logic [STAGES-1:0][WIDTH-1:0]  a_n;
  logic [STAGES-1:0][WIDTH-1:0]  bx_n;
  logic [STAGES-1:0][WIDTH-1:0]  y_n;
  logic                          ovf_n;
  logic                          zero_n;

  logic [WIDTH-1:0]              ai;
  logic [WIDTH-1:0]              bi;
  logic [WIDTH-1:0]              yi;
  logic                          ci;

  // Whole pipe moves together; a held result freezes every stage.
  assign OUT_VALID = v_r[STAGES-1];
  assign adv       = !OUT_VALID || OUT_READY;
  assign IN_READY  = adv && !RST;
  assign take      = IN_VALID && IN_READY;

  // Slice k sees the live operands for k = 0, else the stage k-1
  // registers; each slice is a ripple of full-adder cells.
  always_comb begin
    a_n  = '0;
    bx_n = '0;
    y_n  = '0;
    c_n  = '0;
    ai   = A;
    bi   = B ^ {WIDTH{SnA}};
    yi   = '0;
    ci   = SnA;
    for (int k = 0; k < STAGES; k++) begin
      for (int j = 0; j < S; j++) begin
        yi[k*S+j] = ai[k*S+j] ^ bi[k*S+j] ^ ci;
        ci = (ai[k*S+j] & bi[k*S+j])
           | (ci & (ai[k*S+j] ^ bi[k*S+j]));
      end
      a_n[k]  = ai;
      bx_n[k] = bi;
      y_n[k]  = yi;
      c_n[k]  = ci;
      if (k < STAGES - 1) begin
        ai = a_r[k];
        bi = bx_r[k];
        yi = y_r[k];
        ci = c_r[k];
      end
    end
  end

  assign ovf_n =
    (a_n[STAGES-1][WIDTH-1] == bx_n[STAGES-1][WIDTH-1])
    && (y_n[STAGES-1][WIDTH-1] != a_n[STAGES-1][WIDTH-1]);
  assign zero_n = (y_n[STAGES-1] == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_r    <= '0;
      c_r    <= '0;
      a_r    <= '0;
      bx_r   <= '0;
      y_r    <= '0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (adv) begin
      v_r    <= STAGES'({v_r, take});
      c_r    <= c_n;
      a_r    <= a_n;
      bx_r   <= bx_n;
      y_r    <= y_n;
      ovf_r  <= ovf_n;
      zero_r <= zero_n;
    end
  end

  // Final-stage operand copies are consumed only through ovf_n.
  logic unused_ops;
  assign unused_ops = ^{a_r[STAGES-1], bx_r[STAGES-1]};

  assign Y    = y_r[STAGES-1];
  assign CO   = c_r[STAGES-1];
  assign OVF  = ovf_r;
  assign ZERO = zero_r;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three configurations (32/4, 8/1, 8/8)
// checked against an integer-arithmetic model through one scoreboard.
module tb_pipelined_add_sub;

  localparam int ND = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ND-1:0]   iv;
  logic [ND-1:0]   ordy;
  logic [ND-1:0]   sna;
  logic [31:0]     a [ND];
  logic [31:0]     b [ND];
  wire  [ND-1:0]   ir;
  wire  [ND-1:0]   ov;
  wire  [ND-1:0]   co;
  wire  [ND-1:0]   ovf;
  wire  [ND-1:0]   zr;
  wire  [31:0]     y0;
  wire  [7:0]      y1;
  wire  [7:0]      y2;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u0 (
    .CLK(clk), .RST(rst), .IN_VALID(iv[0]), .IN_READY(ir[0]),
    .A(a[0]), .B(b[0]), .SnA(sna[0]), .OUT_VALID(ov[0]),
    .OUT_READY(ordy[0]), .Y(y0), .CO(co[0]), .OVF(ovf[0]),
    .ZERO(zr[0])
  );

  pipelined_add_sub #(.WIDTH(8), .STAGES(1)) u1 (
    .CLK(clk), .RST(rst), .IN_VALID(iv[1]), .IN_READY(ir[1]),
    .A(a[1][7:0]), .B(b[1][7:0]), .SnA(sna[1]), .OUT_VALID(ov[1]),
    .OUT_READY(ordy[1]), .Y(y1), .CO(co[1]), .OVF(ovf[1]),
    .ZERO(zr[1])
  );

  pipelined_add_sub #(.WIDTH(8), .STAGES(8)) u2 (
    .CLK(clk), .RST(rst), .IN_VALID(iv[2]), .IN_READY(ir[2]),
    .A(a[2][7:0]), .B(b[2][7:0]), .SnA(sna[2]), .OUT_VALID(ov[2]),
    .OUT_READY(ordy[2]), .Y(y2), .CO(co[2]), .OVF(ovf[2]),
    .ZERO(zr[2])
  );

  always #5 clk = ~clk;

  typedef struct {
    int          d;
    logic [31:0] y;
    logic        co;
    logic        ovf;
    logic        zero;
    int          due;
    int          st;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] y;
    logic        co;
    logic        ovf;
    logic        z;
  } vec_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt [ND];
  logic        held [ND];
  logic [34:0] saved [ND];
  vec_t        t32 [5];
  vec_t        t8 [5];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(int d);
    return (d == 0) ? 32 : 8;
  endfunction

  function automatic int stg(int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
  endfunction

  function automatic logic [31:0] gety(int d);
    if (d == 0) return y0;
    if (d == 1) return {24'b0, y1};
    return {24'b0, y2};
  endfunction

  // Plain integer arithmetic: unsigned result for Y/CO,
  // signed result range for OVF.
  function automatic exp_t model(int d, logic [31:0] av,
                                 logic [31:0] bv, logic s);
    exp_t   e;
    longint one, md, ua, ub, sa, sb, r, u;
    one = 1;
    md  = one << wid(d);
    ua  = longint'(av) & (md - 1);
    ub  = longint'(bv) & (md - 1);
    sa  = (ua >= (md >> 1)) ? ua - md : ua;
    sb  = (ub >= (md >> 1)) ? ub - md : ub;
    r   = s ? sa - sb : sa + sb;
    u   = s ? ua - ub : ua + ub;
    e.d    = d;
    e.y    = 32'(u & (md - 1));
    e.co   = s ? (ua >= ub) : (u >= md);
    e.ovf  = (r >= (md >> 1)) || (r < -(md >> 1));
    e.zero = (e.y == 32'd0);
    e.due  = 0;
    e.st   = 0;
    return e;
  endfunction

  task automatic chk(bit ok, string nm,
                     logic [63:0] act, logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin : cmp
    exp_t        e;
    logic [34:0] outs;
    logic [34:0] want;
    for (int d = 0; d < ND; d++) begin
      outs = {zr[d], ovf[d], co[d], gety(d)};
      if (rst) begin
        chk(!ov[d] && !ir[d] && outs == '0, "reset_state",
            {ov[d], ir[d], outs}, 64'd0);
        held[d] = 1'b0;
      end else begin
        chk(ir[d] == (!ov[d] || ordy[d]), "in_ready",
            64'(ir[d]), 64'(!ov[d] || ordy[d]));
        if (held[d])
          chk(ov[d] && outs == saved[d], "stall_hold",
              {ov[d], outs}, {1'b1, saved[d]});
        if (ov[d]) begin
          if (q.size() == 0 || q[0].d != d) begin
            chk(1'b0, "unexpected_out", outs, 64'd0);
          end else if (ordy[d]) begin
            e = q.pop_front();
            want = {e.zero, e.ovf, e.co, e.y};
            chk(outs == want, "result", outs, want);
            chk(cyc == e.due + stall_cnt[d] - e.st, "timing",
                64'(cyc), 64'(e.due + stall_cnt[d] - e.st));
          end
        end
        if (iv[d] && ir[d]) begin
          e     = model(d, a[d], b[d], sna[d]);
          e.due = cyc + stg(d);
          e.st  = stall_cnt[d];
          q.push_back(e);
        end
        held[d]  = ov[d] && !ordy[d];
        saved[d] = outs;
        if (held[d]) stall_cnt[d]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int d, logic [31:0] av, logic [31:0] bv,
                      logic s);
    bit acc;
    acc   = 1'b0;
    iv[d] = 1'b1;
    a[d]  = av;
    b[d]  = bv;
    sna[d] = s;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = ir[d];
      step();
    end
    if (!acc) chk(1'b0, "send_timeout", 64'd0, 64'd1);
    iv[d] = 1'b0;
  endtask

  task automatic expect_next(int d, logic [31:0] ey, logic eco,
                             logic eovf, logic ez, int lat);
    int  k;
    bit  seen;
    k    = 1;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (ov[d]) seen = 1'b1;
      else begin
        step();
        k++;
      end
    end
    chk(seen && k == lat, "latency", 64'(k), 64'(lat));
    chk({zr[d], ovf[d], co[d], gety(d)} == {ez, eovf, eco, ey},
        "literal", {zr[d], ovf[d], co[d], gety(d)},
        {ez, eovf, eco, ey});
    step();
  endtask

  task automatic drain(int d);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    chk(q.size() == 0, "drain", 64'(q.size()), 64'd0);
    repeat (3) step();
  endtask

  task automatic directed(int d);
    vec_t v;
    for (int i = 0; i < 5; i++) begin
      v = (d == 0) ? t32[i] : t8[i];
      send(d, v.a, v.b, v.s);
      expect_next(d, v.y, v.co, v.ovf, v.z, stg(d));
    end
  endtask

  task automatic stream(int d);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          if (i == 4) repeat (2) step();
          send(d, 32'(i), 32'(i), i[0]);
        end
      end
      begin
        int n;
        n = 0;
        while (!ov[d] && n < 100) begin
          step();
          n++;
        end
        ordy[d] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk(!ir[d] && ov[d], "stall_ready",
              {ir[d], ov[d]}, 64'd1);
          step();
        end
        ordy[d] = 1'b1;
      end
    join
    drain(d);
  endtask

  task automatic reset_test(int d);
    for (int i = 0; i < 3; i++)
      send(d, 32'(i + 10), 32'(i + 1), 1'b0);
    #1 rst = 1'b1;
    #1;
    chk(!ov[d] && !ir[d] && gety(d) == 0 && !co[d] && !ovf[d]
        && !zr[d], "async_reset",
        {ov[d], ir[d], co[d], ovf[d], zr[d], gety(d)}, 64'd0);
    q.delete();
    #1 rst = 1'b0;
    step();
    send(d, 32'd3, 32'd2, 1'b1);
    expect_next(d, 32'd1, 1'b1, 1'b0, 1'b0, stg(d));
    drain(d);
  endtask

  function automatic logic [31:0] rv(int d);
    logic [31:0] m;
    m = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(5))
      0: return 32'd0;
      1: return m;
      2: return (m >> 1) + 32'd1;
      3: return m >> 1;
      default: return $urandom & m;
    endcase
  endfunction

  task automatic random_run(int d, int n);
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(3) == 0) step();
          send(d, rv(d), rv(d), 1'($urandom_range(1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ordy[d] = ($urandom_range(3) != 0);
          step();
        end
        ordy[d] = 1'b1;
      end
    join
    drain(d);
  endtask

  task automatic pin_model();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      e = model(0, t32[i].a, t32[i].b, t32[i].s);
      chk({e.y, e.co, e.ovf, e.zero}
          == {t32[i].y, t32[i].co, t32[i].ovf, t32[i].z},
          "model_pin32", {e.y, e.co, e.ovf, e.zero},
          {t32[i].y, t32[i].co, t32[i].ovf, t32[i].z});
      e = model(1, t8[i].a, t8[i].b, t8[i].s);
      chk({e.y, e.co, e.ovf, e.zero}
          == {t8[i].y, t8[i].co, t8[i].ovf, t8[i].z},
          "model_pin8", {e.y, e.co, e.ovf, e.zero},
          {t8[i].y, t8[i].co, t8[i].ovf, t8[i].z});
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    t32[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0,
               32'h0000_0000, 1'b1, 1'b0, 1'b1};
    t32[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
               32'h8000_0000, 1'b0, 1'b1, 1'b0};
    t32[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1,
               32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    t32[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1,
               32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    t32[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1,
               32'h0000_0000, 1'b1, 1'b0, 1'b1};
    t8[0]  = '{32'h01, 32'hFF, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1};
    t8[1]  = '{32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0};
    t8[2]  = '{32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1, 1'b0};
    t8[3]  = '{32'h05, 32'h07, 1'b1, 32'hFE, 1'b0, 1'b0, 1'b0};
    t8[4]  = '{32'h78, 32'h78, 1'b1, 32'h00, 1'b1, 1'b0, 1'b1};
    for (int d = 0; d < ND; d++) begin
      a[d]         = '0;
      b[d]         = '0;
      stall_cnt[d] = 0;
      held[d]      = 1'b0;
      saved[d]     = '0;
    end
    iv   = '0;
    sna  = '0;
    ordy = '1;
    rst  = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    pin_model();
    for (int d = 0; d < ND; d++) begin
      directed(d);
      stream(d);
      reset_test(d);
      random_run(d, (d == 0) ? 2000 : 5000);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
